// File: rtl/sd_cmd_host.sv
// ============================================================================
//  Module   : sd_cmd_host
//  Brief    : SD CMD-line initiator. Sends a CRC7-protected 48-bit command
//             frame and captures the card's 48/136-bit response.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_cmd_host #(
    parameter int CLK_DIV = 2,
    parameter int NCR_MAX = 64,
    parameter int NCC_GAP = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_cmd_valid,
    output logic         o_cmd_ready,
    input  logic [5:0]   i_cmd_index,
    input  logic [31:0]  i_cmd_arg,
    input  logic [1:0]   i_resp_type,
    output logic [135:0] o_resp,
    output logic         o_done,
    output logic         o_crc_err,
    output logic         o_timeout,
    output logic         o_sd_clk,
    output logic         o_sd_cmd,
    output logic         o_sd_cmd_oe,
    input  logic         i_sd_cmd
);

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_MAX = (NCR_MAX > 136) ? ((NCR_MAX > NCC_GAP) ? NCR_MAX : NCC_GAP)
                                             : ((NCC_GAP > 136) ? NCC_GAP : 136);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_RECV = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    state_t             r_state;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [CNT_W-1:0]   r_cnt;
    logic [47:0]        r_frame;
    logic [1:0]         r_resp_type;

    // CRC7, polynomial x^7 + x^3 + 1, zero seed, MSB first
    function automatic logic [6:0] crc7_40(input logic [39:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:0], 1'b0};
            if (fb) begin
                crc = crc ^ 7'h09;
            end
        end
        return crc;
    endfunction

    logic           w_div_term;
    logic           w_rise;
    logic           w_fall;
    logic [39:0]    w_cmd_head;
    logic [6:0]     w_cmd_crc;
    logic [135:0]   w_resp_next;
    logic [6:0]     w_resp_crc;
    logic [CNT_W-1:0] w_resp_len;
    logic           w_last_bit;
    logic           w_resp_bad;

    assign w_div_term  = (r_div_cnt == DIV_W'(CLK_DIV - 1));
    assign w_rise      = w_div_term & ~o_sd_clk;
    assign w_fall      = w_div_term &  o_sd_clk;
    assign w_cmd_head  = {2'b01, i_cmd_index, i_cmd_arg};
    assign w_cmd_crc   = crc7_40(w_cmd_head);
    assign w_resp_next = {o_resp[134:0], i_sd_cmd};
    assign w_resp_crc  = crc7_40(w_resp_next[47:8]);
    assign w_resp_len  = (r_resp_type == 2'd2) ? CNT_W'(136) : CNT_W'(48);
    assign w_last_bit  = ((r_cnt + CNT_W'(1)) == w_resp_len);
    // Only R1-class responses carry a CRC the host can verify
    assign w_resp_bad  = (r_resp_type == 2'd1)
                       ? ((w_resp_crc != w_resp_next[7:1]) || !w_resp_next[0])
                       : !w_resp_next[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_div_cnt   <= '0;
            r_cnt       <= '0;
            r_frame     <= '0;
            r_resp_type <= 2'd0;
            o_cmd_ready <= 1'b1;
            o_resp      <= '0;
            o_done      <= 1'b0;
            o_crc_err   <= 1'b0;
            o_timeout   <= 1'b0;
            o_sd_clk    <= 1'b0;
            o_sd_cmd    <= 1'b1;
            o_sd_cmd_oe <= 1'b0;
        end else begin
            if (w_div_term) begin
                r_div_cnt <= '0;
                o_sd_clk  <= ~o_sd_clk;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end

            o_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid && o_cmd_ready) begin
                        o_cmd_ready <= 1'b0;
                        r_resp_type <= i_resp_type;
                        r_frame     <= {w_cmd_head, w_cmd_crc, 1'b1};
                        o_resp      <= '0;
                        o_crc_err   <= 1'b0;
                        o_timeout   <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (w_fall) begin
                        // After 48 driven bits the end bit has been held a full SD clock
                        if (r_cnt == CNT_W'(48)) begin
                            o_sd_cmd_oe <= 1'b0;
                            o_sd_cmd    <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= (r_resp_type != 2'd0) ? ST_WAIT : ST_GAP;
                        end else begin
                            o_sd_cmd_oe <= 1'b1;
                            o_sd_cmd    <= r_frame[47];
                            r_frame     <= {r_frame[46:0], 1'b1};
                            r_cnt       <= r_cnt + CNT_W'(1);
                        end
                    end
                end

                ST_WAIT: begin
                    if (w_rise) begin
                        if (!i_sd_cmd) begin
                            o_resp  <= w_resp_next;
                            r_cnt   <= CNT_W'(1);
                            r_state <= ST_RECV;
                        end else if (r_cnt == CNT_W'(NCR_MAX - 1)) begin
                            o_timeout <= 1'b1;
                            r_cnt     <= '0;
                            r_state   <= ST_GAP;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end

                ST_RECV: begin
                    if (w_rise) begin
                        o_resp <= w_resp_next;
                        if (w_last_bit) begin
                            o_crc_err <= w_resp_bad;
                            r_cnt     <= '0;
                            r_state   <= ST_GAP;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end

                ST_GAP: begin
                    if (w_rise) begin
                        if (r_cnt == CNT_W'(NCC_GAP - 1)) begin
                            o_done      <= 1'b1;
                            o_cmd_ready <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    o_cmd_ready <= 1'b1;
                    o_sd_cmd_oe <= 1'b0;
                    o_sd_cmd    <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
